contador_ad_bcd_mod: RTL and testbench
======================================

# contador_ad_bcd_mod

Parametrised two-digit BCD up/down counter: the successor of the fixed 0–59 minutes/seconds counter, for any field of the clock/calendar display (seconds, minutes, hours 0–23, day 1–31, month 1–12). One instance per field, with:
- edge-detected manual edit plus optional auto-repeat;
- timebase-driven run mode with carry output for cascading;
- validated parallel BCD load from the RTC read path.

## Interface
Parameters:
- MIN_VAL, 0, lowest legal count (0..98)
- MAX_VAL, 59, highest legal count (MIN_VAL+1..99)
- EDIT_CODE, 2, en_count value selecting edit mode
- RUN_CODE, 3, en_count value selecting run mode
- HOLD_CYCLES, 50000000, held-button delay before first repeat (AUTOREPEAT_EN only)
- RPT_CYCLES, 10000000, repeat period (AUTOREPEAT_EN only)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- en_count  in  4  mode select
- enUP  in  1  increment button, level, debounced upstream
- enDOWN  in  1  decrement button, level
- tick  in  1  one-cycle run-mode increment strobe
- load  in  1  one-cycle parallel load strobe
- load_digit1  in  4  BCD tens to load
- load_digit0  in  4  BCD units to load
- digit1  out  4  BCD tens, registered
- digit0  out  4  BCD units, registered
- carry  out  1  one-cycle pulse on run-mode wrap MAX_VAL→MIN_VAL
- load_err  out  1  one-cycle pulse on rejected load

## Operation
- Internal count q, width clog2(MAX_VAL+1). Digits are registered BCD of q and are updated on the same edge as q.
- Edge detect:
  - enUP_tick = enUP & ~enUP_prev; likewise for enDOWN.
  - enUP_prev and enDOWN_prev are reset to 1, so a button held through reset release causes no step.
- Priority per cycle: load > edit > run > hold.
- Load:
  - Accepted only if both digits ≤ 9 and MIN_VAL ≤ 10·d1+d0 ≤ MAX_VAL. If accepted, q takes that value.
  - Otherwise q is unchanged and load_err = 1 for one cycle.
  - Load is honoured in any mode.
- Edit (en_count == EDIT_CODE):
  - enUP_tick: q+1, wrapping MAX_VAL→MIN_VAL.
  - enDOWN_tick: q−1, wrapping MIN_VAL→MAX_VAL.
  - Both ticks in the same cycle: no change.
  - carry is never asserted in edit mode; tick is ignored.
- Run (en_count == RUN_CODE):
  - tick: q+1.
  - At MAX_VAL, q goes to MIN_VAL and carry = 1 for that cycle.
  - Buttons are ignored.
- Any other en_count: q holds, carry = 0, auto-repeat FSM returns to IDLE.
- q can never leave [MIN_VAL, MAX_VAL]. Wrap compares against MAX_VAL/MIN_VAL, never against 2^N.

## Timing
- Reset values:
  - q = MIN_VAL; digit1/digit0 = BCD(MIN_VAL)
  - carry = 0, load_err = 0
  - edge registers = 1
  - repeat FSM = IDLE, repeat counter = 0
- Latency:
  - An input sampled at rising edge E (button first sampled high, tick, load) updates digits/carry/load_err at E itself; they are visible in the cycle following E.
  - Exactly one step per qualifying edge.
- carry and load_err are single-cycle pulses, never stretched.
- Reset asserted mid-count or mid-repeat clears everything immediately, without waiting for clk.

## Configuration
- Macro AUTOREPEAT_EN.
- Defined: edit-mode auto-repeat FSM is compiled in.
  - States: IDLE → HOLD on a single-button tick (step taken).
  - HOLD → REPEAT after HOLD_CYCLES further cycles held, emitting one step.
  - REPEAT emits one step every RPT_CYCLES while held.
  - Release, both buttons high, load, or leaving edit mode → IDLE.
- Undefined: FSM and counter are absent. Steps occur only on rising edges. HOLD_CYCLES and RPT_CYCLES are unused.

## Test plan
- Reset with defaults → digits 0/0. Hold enUP high across reset release → still 0/0 after 5 cycles.
- MIN_VAL=1, MAX_VAL=12, edit:
  - From 12, enUP pulse → 0/1.
  - From 1, enDOWN pulse → 1/2.
  - enUP and enDOWN rising in the same cycle → unchanged.
- Run mode, defaults, q=58: two tick strobes → 5/9 then 0/0, carry high exactly on the second update cycle. Buttons toggled meanwhile → no effect.
- Load 2/3 with MAX_VAL=23 → 2/3, load_err 0. Then:
  - Load 2/4 → unchanged, load_err one cycle.
  - Load 1/10 → unchanged, load_err one cycle.
  - Load concurrent with tick → load wins.
- AUTOREPEAT_EN, HOLD_CYCLES=4, RPT_CYCLES=2, from 0, enUP held 12 cycles → steps at cycles 1, 5, 7, 9, 11, count 5. Release → no further steps.
- Reset asserted asynchronously between edges during REPEAT at count 37 → outputs 0/0 immediately. After release, holding enUP produces no step until it is released and pressed again.

Source files
------------

// File: rtl/contador_ad_bcd_mod.sv
// contador_ad_bcd_mod: two-digit BCD up/down counter with edit, run and load.
// Define AUTOREPEAT_EN to compile in the held-button auto-repeat FSM.
module contador_ad_bcd_mod #(
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 59,
    parameter int EDIT_CODE   = 2,
    parameter int RUN_CODE    = 3,
    parameter int HOLD_CYCLES = 50000000,
    parameter int RPT_CYCLES  = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] en_count,
    input  logic       enUP,
    input  logic       enDOWN,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_digit1,
    input  logic [3:0] load_digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       carry,
    output logic       load_err
);
    localparam int W = $clog2(MAX_VAL + 1);
    localparam logic [W-1:0] QMIN = W'(MIN_VAL);
    localparam logic [W-1:0] QMAX = W'(MAX_VAL);

    logic [W-1:0] q_q, q_d;
    logic [3:0]   d1_q, d1_d, d0_q, d0_d;
    logic         carry_q, carry_d;
    logic         err_q, err_d;
    logic         up_prev_q, dn_prev_q;
    logic         up_tick, dn_tick;
    logic         edit_mode, run_mode;
    logic         rpt_up, rpt_dn;
    logic         step_up, step_dn;
    logic         ld_ok;
    int           ld_val;

    assign up_tick   = enUP & ~up_prev_q;
    assign dn_tick   = enDOWN & ~dn_prev_q;
    assign edit_mode = (en_count == 4'(EDIT_CODE));
    assign run_mode  = (en_count == 4'(RUN_CODE));
    assign step_up   = up_tick | rpt_up;
    assign step_dn   = dn_tick | rpt_dn;

    assign ld_val = int'(load_digit1) * 10 + int'(load_digit0);
    assign ld_ok  = (load_digit1 <= 4'd9) && (load_digit0 <= 4'd9) &&
                    (ld_val >= MIN_VAL) && (ld_val <= MAX_VAL);

`ifdef AUTOREPEAT_EN
    localparam int CMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rpt_state_e;

    rpt_state_e    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          held;

    // Only the button that started the hold, alone, keeps it alive.
    assign held = dir_q ? (enUP & ~enDOWN) : (enDOWN & ~enUP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            dir_q <= 1'b1;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        rpt_up = 1'b0;
        rpt_dn = 1'b0;
        if (load || !edit_mode) begin
            st_d  = IDLE;
            cnt_d = '0;
        end else if (up_tick ^ dn_tick) begin
            st_d  = HOLD;
            cnt_d = '0;
            dir_d = up_tick;
        end else if (!held) begin
            st_d  = IDLE;
            cnt_d = '0;
        end else begin
            unique case (st_q)
                HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        st_d   = REPEAT;
                        cnt_d  = '0;
                        rpt_up = dir_q;
                        rpt_dn = ~dir_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                REPEAT: begin
                    if (cnt_q == CW'(RPT_CYCLES - 1)) begin
                        cnt_d  = '0;
                        rpt_up = dir_q;
                        rpt_dn = ~dir_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{HOLD_CYCLES, RPT_CYCLES};
    assign rpt_up     = 1'b0;
    assign rpt_dn     = 1'b0;
`endif

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (ld_ok) q_d = W'(ld_val);
            else       err_d = 1'b1;
        end else if (edit_mode) begin
            unique case (1'b1)
                step_up && !step_dn: q_d = (q_q == QMAX) ? QMIN : q_q + W'(1);
                step_dn && !step_up: q_d = (q_q == QMIN) ? QMAX : q_q - W'(1);
                default:             q_d = q_q;
            endcase
        end else if (run_mode && tick) begin
            if (q_q == QMAX) begin
                q_d     = QMIN;
                carry_d = 1'b1;
            end else begin
                q_d = q_q + W'(1);
            end
        end
        // Digits are re-derived from the next count so they move on the same edge.
        d1_d = 4'(int'(q_d) / 10);
        d0_d = 4'(int'(q_d) % 10);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= QMIN;
            d1_q      <= 4'(MIN_VAL / 10);
            d0_q      <= 4'(MIN_VAL % 10);
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            up_prev_q <= 1'b1;
            dn_prev_q <= 1'b1;
        end else begin
            q_q       <= q_d;
            d1_q      <= d1_d;
            d0_q      <= d0_d;
            carry_q   <= carry_d;
            err_q     <= err_d;
            up_prev_q <= enUP;
            dn_prev_q <= enDOWN;
        end
    end

    assign digit1   = d1_q;
    assign digit0   = d0_q;
    assign carry    = carry_q;
    assign load_err = err_q;
endmodule

// File: tb/tb_contador_ad_bcd_mod.sv
// Bench for contador_ad_bcd_mod: three ranges (0-59, 1-12, 0-23) share one stimulus
// stream and are checked against an arithmetic reference model.
module tb_contador_ad_bcd_mod;
    localparam int NI   = 3;
    localparam int HOLD = 4;
    localparam int RPT  = 2;
`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    int mn[NI] = '{0, 1, 0};
    int mx[NI] = '{59, 12, 23};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] en_count = 4'd0;
    logic       enUP = 1'b0;
    logic       enDOWN = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld1 = 4'd0;
    logic [3:0] ld0 = 4'd0;
    logic [3:0] d1 [NI];
    logic [3:0] d0 [NI];
    logic       cy [NI];
    logic       le [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    contador_ad_bcd_mod #(.MIN_VAL(0), .MAX_VAL(59), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)) u0 (
        .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
        .tick(tick), .load(load), .load_digit1(ld1), .load_digit0(ld0),
        .digit1(d1[0]), .digit0(d0[0]), .carry(cy[0]), .load_err(le[0]));
    contador_ad_bcd_mod #(.MIN_VAL(1), .MAX_VAL(12), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)) u1 (
        .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
        .tick(tick), .load(load), .load_digit1(ld1), .load_digit0(ld0),
        .digit1(d1[1]), .digit0(d0[1]), .carry(cy[1]), .load_err(le[1]));
    contador_ad_bcd_mod #(.MIN_VAL(0), .MAX_VAL(23), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)) u2 (
        .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
        .tick(tick), .load(load), .load_digit1(ld1), .load_digit0(ld0),
        .digit1(d1[2]), .digit0(d0[2]), .carry(cy[2]), .load_err(le[2]));

    // Reference model: count as a plain integer, held-button age in cycles.
    int mq[NI];
    bit mc[NI];
    bit me[NI];
    bit pu, pd, hdir;
    int held;

    function automatic int nxt(int k, int q, bit up);
        int r;
        r = mx[k] - mn[k] + 1;
        if (up) return mn[k] + (q - mn[k] + 1) % r;
        return mn[k] + (q - mn[k] - 1 + r) % r;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit ut, dt, ed, rn, sup, sdn;
        int v;
        if (reset) begin
            for (int k = 0; k < NI; k++) begin
                mq[k] = mn[k];
                mc[k] = 1'b0;
                me[k] = 1'b0;
            end
            pu = 1'b1;
            pd = 1'b1;
            held = 0;
        end else begin
            ut = enUP && !pu;
            dt = enDOWN && !pd;
            ed = (en_count == 4'd2);
            rn = (en_count == 4'd3);
            sup = 1'b0;
            sdn = 1'b0;
            if (load || !ed) begin
                held = 0;
            end else if (ut != dt) begin
                held = 1;
                hdir = ut;
                sup = ut;
                sdn = dt;
            end else if (held > 0 && (hdir ? (enUP && !enDOWN) : (enDOWN && !enUP))) begin
                held++;
                if (AR && held >= 1 + HOLD && (held - 1 - HOLD) % RPT == 0) begin
                    sup = hdir;
                    sdn = !hdir;
                end
            end else begin
                held = 0;
            end
            v = int'(ld1) * 10 + int'(ld0);
            for (int k = 0; k < NI; k++) begin
                mc[k] = 1'b0;
                me[k] = 1'b0;
                if (load) begin
                    if (ld1 <= 9 && ld0 <= 9 && v >= mn[k] && v <= mx[k]) mq[k] = v;
                    else me[k] = 1'b1;
                end else if (ed) begin
                    if (sup) mq[k] = nxt(k, mq[k], 1'b1);
                    else if (sdn) mq[k] = nxt(k, mq[k], 1'b0);
                end else if (rn && tick) begin
                    if (mq[k] == mx[k]) mc[k] = 1'b1;
                    mq[k] = nxt(k, mq[k], 1'b1);
                end
            end
            pu = enUP;
            pd = enDOWN;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        enUP = 1'b1;
        en_count = 4'd2;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({d1[k], d0[k], cy[k], le[k]} !== {4'(mn[k] / 10), 4'(mn[k] % 10), 2'b00}) begin
                errors++;
                $display("FAIL reset_state k=%0d got %0d/%0d c%b e%b want %0d/%0d c0 e0",
                         k, d1[k], d0[k], cy[k], le[k], mn[k] / 10, mn[k] % 10);
            end
        end
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({d1[0], d0[0]} !== 8'h00) begin
            errors++;
            $display("FAIL held_through_reset got %0d/%0d want 0/0", d1[0], d0[0]);
        end
        enUP = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_edit();
        logic [7:0] want [3] = '{8'h01, 8'h12, 8'h12};
        en_count = 4'd2;
        load = 1'b1; ld1 = 4'd1; ld0 = 4'd2;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enUP = (i != 1);
            enDOWN = (i != 0);
            @(negedge clk);
            enUP = 1'b0;
            enDOWN = 1'b0;
            @(negedge clk);
            checks++;
            if ({d1[1], d0[1]} !== want[i]) begin
                errors++;
                $display("FAIL edit_wrap step=%0d got %0d/%0d want %h", i, d1[1], d0[1], want[i]);
            end
        end
        for (int n = 0; n < 80; n++) begin
            enUP = ($urandom_range(0, 2) == 0);
            enDOWN = ($urandom_range(0, 2) == 0);
            tick = $urandom_range(0, 1);
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                checks++;
                if ({d1[k], d0[k], cy[k], le[k]} !==
                    {4'(mq[k] / 10), 4'(mq[k] % 10), mc[k], me[k]}) begin
                    errors++;
                    $display("FAIL edit_rand k=%0d got %0d/%0d c%b e%b want %0d c%b e%b",
                             k, d1[k], d0[k], cy[k], le[k], mq[k], mc[k], me[k]);
                end
            end
        end
        enUP = 1'b0;
        enDOWN = 1'b0;
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run();
        logic [8:0] want [3] = '{9'h0b2, 9'h001, 9'h000};
        en_count = 4'd3;
        load = 1'b1; ld1 = 4'd5; ld0 = 4'd8;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick = (i < 2);
            enUP = ~enUP;
            enDOWN = (i == 1);
            @(negedge clk);
            checks++;
            if ({d1[0], d0[0], cy[0]} !== want[i]) begin
                errors++;
                $display("FAIL run_carry step=%0d got %0d/%0d c%b want %h",
                         i, d1[0], d0[0], cy[0], want[i]);
            end
        end
        for (int n = 0; n < 120; n++) begin
            tick = ($urandom_range(0, 3) != 0);
            enUP = $urandom_range(0, 1);
            enDOWN = $urandom_range(0, 1);
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                checks++;
                if ({d1[k], d0[k], cy[k], le[k]} !==
                    {4'(mq[k] / 10), 4'(mq[k] % 10), mc[k], me[k]}) begin
                    errors++;
                    $display("FAIL run_rand k=%0d got %0d/%0d c%b e%b want %0d c%b e%b",
                             k, d1[k], d0[k], cy[k], le[k], mq[k], mc[k], me[k]);
                end
            end
        end
        tick = 1'b0;
        enUP = 1'b0;
        enDOWN = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        logic [3:0] l1 [5] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd1};
        logic [3:0] l0 [5] = '{4'd3, 4'd4, 4'd3, 4'd10, 4'd5};
        logic [8:0] want [5] = '{9'h046, 9'h047, 9'h046, 9'h047, 9'h02a};
        en_count = 4'd1;
        for (int i = 0; i < 5; i++) begin
            // The last entry lands a load on a run-mode tick; the load must win.
            en_count = (i == 4) ? 4'd3 : 4'd1;
            tick = (i == 4);
            load = (i != 2);
            ld1 = l1[i];
            ld0 = l0[i];
            @(negedge clk);
            checks++;
            if ({d1[2], d0[2], le[2]} !== want[i]) begin
                errors++;
                $display("FAIL load_check step=%0d got %0d/%0d e%b want %h",
                         i, d1[2], d0[2], le[2], want[i]);
            end
        end
        for (int n = 0; n < 150; n++) begin
            load = $urandom_range(0, 1);
            ld1 = 4'($urandom_range(0, 10));
            ld0 = 4'($urandom_range(0, 11));
            tick = $urandom_range(0, 1);
            en_count = 4'($urandom_range(0, 3));
            enUP = $urandom_range(0, 1);
            enDOWN = $urandom_range(0, 1);
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                checks++;
                if ({d1[k], d0[k], cy[k], le[k]} !==
                    {4'(mq[k] / 10), 4'(mq[k] % 10), mc[k], me[k]}) begin
                    errors++;
                    $display("FAIL load_rand k=%0d got %0d/%0d c%b e%b want %0d c%b e%b",
                             k, d1[k], d0[k], cy[k], le[k], mq[k], mc[k], me[k]);
                end
            end
        end
        load = 1'b0;
        tick = 1'b0;
        enUP = 1'b0;
        enDOWN = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_autorepeat();
        int steps [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
        en_count = 4'd2;
        load = 1'b1; ld1 = 4'd0; ld0 = 4'd0;
        @(negedge clk);
        load = 1'b0;
        enUP = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 12) enUP = 1'b0;
            @(negedge clk);
            checks++;
            if ({d1[0], d0[0]} !== {4'(mq[0] / 10), 4'(mq[0] % 10)}) begin
                errors++;
                $display("FAIL autorepeat_model cyc=%0d got %0d/%0d want %0d",
                         c + 1, d1[0], d0[0], mq[0]);
            end
            checks++;
            if (int'(d0[0]) != (AR ? steps[c < 12 ? c : 11] : 1)) begin
                errors++;
                $display("FAIL autorepeat_count cyc=%0d got %0d want %0d",
                         c + 1, d0[0], AR ? steps[c < 12 ? c : 11] : 1);
            end
        end
    endtask

    task automatic test_reset_repeat();
        en_count = 4'd2;
        load = 1'b1; ld1 = 4'd3; ld0 = 4'd5;
        @(negedge clk);
        load = 1'b0;
        enUP = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({d1[0], d0[0]} !== (AR ? 8'h37 : 8'h36)) begin
            errors++;
            $display("FAIL pre_reset_count got %0d/%0d want %h",
                     d1[0], d0[0], AR ? 8'h37 : 8'h36);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({d1[0], d0[0], cy[0], le[0]} !== 10'h000) begin
            errors++;
            $display("FAIL async_reset got %0d/%0d c%b e%b want 0/0", d1[0], d0[0], cy[0], le[0]);
        end
        #1 reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({d1[0], d0[0]} !== 8'h00) begin
                errors++;
                $display("FAIL held_after_reset cyc=%0d got %0d/%0d want 0/0", c, d1[0], d0[0]);
            end
        end
        enUP = 1'b0;
        @(negedge clk);
        enUP = 1'b1;
        @(negedge clk);
        enUP = 1'b0;
        checks++;
        if ({d1[0], d0[0]} !== 8'h01) begin
            errors++;
            $display("FAIL repress_step got %0d/%0d want 0/1", d1[0], d0[0]);
        end
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({d1[k], d0[k]} !== {4'(mq[k] / 10), 4'(mq[k] % 10)}) begin
                errors++;
                $display("FAIL repress_model k=%0d got %0d/%0d want %0d", k, d1[k], d0[k], mq[k]);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_edit();
        test_run();
        test_load();
        test_autorepeat();
        test_reset_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
